// File: rtl/dc_pkg.sv
// Shared definitions for the dc_* clock-domain-crossing blocks:
// handshake state encoding and synchronizer depth.
package dc_pkg;

    localparam logic [1:0] DC_HS_IDLE = 2'd0;
    localparam logic [1:0] DC_HS_REQ  = 2'd1;
    localparam logic [1:0] DC_HS_REL  = 2'd2;

    localparam int DC_SYNC_STAGES = 2;

    typedef enum logic [1:0] {
        HS_IDLE = DC_HS_IDLE,
        HS_REQ  = DC_HS_REQ,
        HS_REL  = DC_HS_REL
    } dc_hs_state_e;

    // A handshake is in flight in every state except IDLE.
    function automatic logic hs_busy(input dc_hs_state_e s);
        return s != HS_IDLE;
    endfunction

endpackage

// File: rtl/dc_synchronizer.sv
// Multi-flop level synchronizer for signals arriving from another clock
// domain. Reset is asynchronous, active-low.
module dc_synchronizer
    import dc_pkg::*;
#(
    parameter int               WIDTH       = 1,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0,
    parameter int               STAGES      = DC_SYNC_STAGES
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [STAGES-1:0][WIDTH-1:0] sync_q;

    // Shift the asynchronous input through the flop chain; only the last
    // stage is used by downstream logic.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sync_q <= {STAGES{RESET_VALUE}};
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d};
        end
    end

    assign q = sync_q[STAGES-1];

endmodule

// File: rtl/dc_handshake_tx.sv
// Source side of a 4-phase req/ack clock-domain crossing.
// Accepts a word on valid/ready, holds it on data_async_o, raises
// req_async_o and waits for the remote ack (brought in through a
// 2-flop synchronizer) to rise and then fall.
// Optional feature macro: DC_HANDSHAKE_TIMEOUT_EN adds a sticky timeout_o
// flag set when a handshake stays outstanding for TIMEOUT_CYCLES cycles.
module dc_handshake_tx
    import dc_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic                  valid_i,
    output logic                  ready_o,
    output logic [DATA_WIDTH-1:0] data_async_o,
    output logic                  req_async_o,
    input  logic                  ack_async_i,
`ifdef DC_HANDSHAKE_TIMEOUT_EN
    output logic                  busy_o,
    output logic                  timeout_o
`else
    output logic                  busy_o
`endif
);

    if (TIMEOUT_CYCLES < 2) begin : g_bad_cfg
        $error("dc_handshake_tx: TIMEOUT_CYCLES must be >= 2");
    end

    dc_hs_state_e state;
    dc_hs_state_e state_next;
    logic         req_next;
    logic         accept;
    logic         ack_sync;
    logic         rstn;

    assign rstn = ~rst;

    dc_synchronizer #(
        .WIDTH       (1),
        .RESET_VALUE (1'b0),
        .STAGES      (DC_SYNC_STAGES)
    ) u_ack_sync (
        .clk  (clk),
        .rstn (rstn),
        .d    (ack_async_i),
        .q    (ack_sync)
    );

    // Next-state, next-req and ready decode. A stale ack seen in IDLE
    // blocks new words until the remote side has released it.
    always_comb begin
        state_next = state;
        req_next   = req_async_o;
        accept     = 1'b0;
        ready_o    = 1'b0;
        case (state)
            HS_IDLE: begin
                ready_o  = ~ack_sync;
                req_next = 1'b0;
                if (valid_i && !ack_sync) begin
                    accept     = 1'b1;
                    req_next   = 1'b1;
                    state_next = HS_REQ;
                end
            end
            HS_REQ: begin
                req_next = 1'b1;
                if (ack_sync) begin
                    req_next   = 1'b0;
                    state_next = HS_REL;
                end
            end
            HS_REL: begin
                req_next = 1'b0;
                if (!ack_sync) begin
                    state_next = HS_IDLE;
                end
            end
            default: begin
                req_next   = 1'b0;
                state_next = HS_IDLE;
            end
        endcase
    end

    // State and request registers; req is a flop output so it cannot glitch
    // on its way into the remote domain.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= HS_IDLE;
            req_async_o <= 1'b0;
        end else begin
            state       <= state_next;
            req_async_o <= req_next;
        end
    end

    // Hold register: the word only changes on an accept, so it is stable for
    // the whole time the receiver may be sampling it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_async_o <= '0;
        end else if (accept) begin
            data_async_o <= data_i;
        end
    end

    assign busy_o = hs_busy(state);

`ifdef DC_HANDSHAKE_TIMEOUT_EN
    localparam int                CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] to_cnt;

    // Count cycles spent outstanding (REQ or REL), saturating; the flag is
    // sticky until reset and purely observational.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            to_cnt    <= '0;
            timeout_o <= 1'b0;
        end else if (accept) begin
            to_cnt <= '0;
        end else if (busy_o && to_cnt != CNT_MAX) begin
            to_cnt <= to_cnt + CNT_W'(1);
            if (to_cnt == CNT_LAST) begin
                timeout_o <= 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_dc_handshake_tx.sv
// Bench for dc_handshake_tx: a remote receiver model (2-flop req sync plus
// programmable ack delay), a transaction-level model of the sender checked
// against the DUT every negedge, and directed tests with literal expectations.
// Build with DC_HANDSHAKE_TIMEOUT_EN defined to exercise the timeout flag.
module tb_dc_handshake_tx;

    localparam int TO = 16;

    logic        clk;
    logic        rst;
    logic [31:0] data_i;
    logic        valid_i;
    logic        ready_o;
    logic [31:0] data_async_o;
    logic        req_async_o;
    logic        ack_async_i;
    logic        busy_o;
`ifdef DC_HANDSHAKE_TIMEOUT_EN
    logic        timeout_o;
`endif

    dc_handshake_tx #(
        .DATA_WIDTH     (32),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .data_i       (data_i),
        .valid_i      (valid_i),
        .ready_o      (ready_o),
        .data_async_o (data_async_o),
        .req_async_o  (req_async_o),
        .ack_async_i  (ack_async_i),
`ifdef DC_HANDSHAKE_TIMEOUT_EN
        .busy_o       (busy_o),
        .timeout_o    (timeout_o)
`else
        .busy_o       (busy_o)
`endif
    );

    int checks = 0;
    int errors = 0;
    bit clk_run = 0;
    bit chk_en  = 0;

    initial begin
        clk = 0;
        forever begin
            #5;
            if (clk_run) clk = ~clk;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req_v);
        checks++;
        if (act !== req_v) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req_v);
        end
    endtask

    // Remote receiver: synchronizes req, captures the word on synced rise,
    // and mirrors the synced req onto ack after rdelay negedges.
    bit          remote_en = 1;
    int          rdelay    = 3;
    logic [31:0] rx_q[$];
    logic        rs1 = 0, rs2 = 0;
    int          rcnt = 0;

    initial begin
        logic prev;
        forever begin
            @(negedge clk);
            if (rst) begin
                rs1 = 0; rs2 = 0; rcnt = 0;
                if (remote_en) ack_async_i = 0;
            end else begin
                prev = rs2;
                rs2  = rs1;
                rs1  = req_async_o;
                if (rs2 && !prev) rx_q.push_back(data_async_o);
                if (remote_en && rs2 != ack_async_i) begin
                    rcnt++;
                    if (rcnt >= rdelay) begin
                        ack_async_i = rs2;
                        rcnt = 0;
                    end
                end else begin
                    rcnt = 0;
                end
            end
        end
    end

    // Transaction-level sender model: phase 0 = idle, 1 = waiting for ack,
    // 2 = waiting for ack release. Ack is visible two samples late.
    int          m_phase = 0;
    logic        m_req = 0;
    logic [31:0] m_data = 0;
    logic        m_as = 0, m_a1 = 0;
    int          m_cnt = 0;
    logic        m_to = 0;
    logic [31:0] sent_q[$];
    int          cyc = 0;
    int          t_ackhi = 0, t_acklo = 0;
    logic        ack_prev = 0;

    initial begin
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                m_phase = 0; m_req = 0; m_data = 0;
                m_as = 0; m_a1 = 0; m_cnt = 0; m_to = 0;
            end else begin
                cyc++;
                if (ack_async_i && !ack_prev) t_ackhi = cyc;
                if (!ack_async_i && ack_prev) t_acklo = cyc;
                ack_prev = ack_async_i;
                if (m_phase != 0) begin
                    if (m_cnt < TO) m_cnt++;
                    if (m_cnt == TO) m_to = 1;
                end
                case (m_phase)
                    0: if (valid_i && !m_as) begin
                        m_data = data_i; m_req = 1; m_phase = 1; m_cnt = 0;
                        sent_q.push_back(data_i);
                    end
                    1: if (m_as) begin m_req = 0; m_phase = 2; end
                    default: if (!m_as) m_phase = 0;
                endcase
                m_as = m_a1;
                m_a1 = ack_async_i;
            end
        end
    end

    // Per-cycle comparison against the model, plus edge timestamps.
    int   t_reqfall = 0, t_rdy = 0;
    logic p_req = 0, p_rdy = 0;

    initial begin
        forever begin
            @(negedge clk);
            if (p_req && !req_async_o) t_reqfall = cyc;
            if (!p_rdy && ready_o) t_rdy = cyc;
            p_req = req_async_o;
            p_rdy = ready_o;
            if (chk_en) begin
                check("model_req", {31'd0, req_async_o}, {31'd0, m_req});
                check("model_data", data_async_o, m_data);
                check("model_busy", {31'd0, busy_o}, {31'd0, m_phase != 0});
                if (!rst)
                    check("model_ready", {31'd0, ready_o}, {31'd0, m_phase == 0 && !m_as});
`ifdef DC_HANDSHAKE_TIMEOUT_EN
                check("model_timeout", {31'd0, timeout_o}, {31'd0, m_to});
`endif
            end
        end
    end

    task automatic wait_ready(input string name);
        int n = 0;
        while (!ready_o && n < 200) begin @(negedge clk); n++; end
        if (!ready_o) begin
            checks++; errors++;
            $display("FAIL %s wait_ready actual=0 required=1", name);
        end
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while ((busy_o || ack_async_i) && n < 300) begin @(negedge clk); n++; end
        if (busy_o || ack_async_i) begin
            checks++; errors++;
            $display("FAIL %s wait_idle actual=busy required=idle", name);
        end
    endtask

    // Called at a negedge; the word is taken at the following posedge.
    task automatic send(input logic [31:0] w, input string name);
        data_i  = w;
        valid_i = 1;
        wait_ready(name);
        @(negedge clk);
        valid_i = 0;
    endtask

    initial begin
        int k;
        logic [31:0] exp3 [3];
        exp3[0] = 32'd1; exp3[1] = 32'd2; exp3[2] = 32'd3;
        rst = 0; valid_i = 0; data_i = 0; ack_async_i = 0;

        // 1: asynchronous reset with the clock stopped
        #3 rst = 1;
        #1;
        check("t1_req", {31'd0, req_async_o}, 32'd0);
        check("t1_data", data_async_o, 32'd0);
        check("t1_busy", {31'd0, busy_o}, 32'd0);
        valid_i = 1;          // ignored while in reset
        clk_run = 1;
        repeat (2) @(negedge clk);
        valid_i = 0;
        rst = 0;
        chk_en = 1;
        @(negedge clk);
        check("t1_ready", {31'd0, ready_o}, 32'd1);
        check("t1_busy_after", {31'd0, busy_o}, 32'd0);

        // 2: single transfer and latency
        rdelay = 3;
        rx_q.delete();
        send(32'hDEADBEEF, "t2");
        check("t2_data", data_async_o, 32'hDEADBEEF);
        check("t2_req", {31'd0, req_async_o}, 32'd1);
        wait_idle("t2");
        check("t2_req_fall_lat", t_reqfall - t_ackhi, 32'd2);
        check("t2_ready_lat", t_rdy - t_acklo, 32'd2);
        check("t2_rx_n", rx_q.size(), 32'd1);
        if (rx_q.size() == 1) check("t2_rx", rx_q[0], 32'hDEADBEEF);

        // 3: valid held across three back-to-back words
        rx_q.delete();
        sent_q.delete();
        k = 0;
        valid_i = 1;
        for (int i = 0; i < 3; i++) begin
            data_i = exp3[i];
            wait_ready("t3");
            k++;
            @(negedge clk);
        end
        valid_i = 0;
        wait_idle("t3");
        check("t3_accepts", k, 32'd3);
        check("t3_rx_n", rx_q.size(), 32'd3);
        check("t3_model_n", sent_q.size(), 32'd3);
        for (int i = 0; i < 3; i++) begin
            if (i < rx_q.size()) check("t3_rx", rx_q[i], exp3[i]);
            if (i < sent_q.size()) check("t3_model", sent_q[i], exp3[i]);
        end

        // 4: stale ack in IDLE blocks acceptance
        rx_q.delete();
        remote_en = 0;
        ack_async_i = 1;
        repeat (3) @(negedge clk);
        data_i = 32'h44;
        valid_i = 1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("t4_ready_blocked", {31'd0, ready_o}, 32'd0);
            check("t4_no_accept", {31'd0, busy_o}, 32'd0);
        end
        ack_async_i = 0;
        remote_en = 1;
        k = 0;
        while (!busy_o && k < 20) begin @(negedge clk); k++; end
        valid_i = 0;
        check("t4_accept_lat", k, 32'd3);
        wait_idle("t4");
        check("t4_rx_n", rx_q.size(), 32'd1);
        if (rx_q.size() == 1) check("t4_rx", rx_q[0], 32'h44);

        // 5: reset in the middle of REQ, then a normal transfer
        rdelay = 20;
        send(32'h5555AAAA, "t5a");
        repeat (3) @(negedge clk);
        check("t5_busy_pre", {31'd0, busy_o}, 32'd1);
        #2 rst = 1;
        #1;
        check("t5_req", {31'd0, req_async_o}, 32'd0);
        check("t5_busy", {31'd0, busy_o}, 32'd0);
        check("t5_data", data_async_o, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 0;
        rdelay = 3;
        rx_q.delete();
        send(32'hA5A50001, "t5b");
        wait_idle("t5");
        check("t5_rx_n", rx_q.size(), 32'd1);
        if (rx_q.size() == 1) check("t5_rx", rx_q[0], 32'hA5A50001);

`ifdef DC_HANDSHAKE_TIMEOUT_EN
        // 6: ack never arrives -> timeout after exactly TO edges
        remote_en = 0;
        ack_async_i = 0;
        check("t6_to_clear", {31'd0, timeout_o}, 32'd0);
        send(32'h66, "t6");
        k = 0;
        while (!timeout_o && k < 40) begin @(negedge clk); k++; end
        check("t6_to_lat", k, 32'd16);
        repeat (5) @(negedge clk);
        check("t6_to_sticky", {31'd0, timeout_o}, 32'd1);
        check("t6_req_held", {31'd0, req_async_o}, 32'd1);
        check("t6_busy_held", {31'd0, busy_o}, 32'd1);
        rst = 1;
        @(negedge clk);
        check("t6_to_reset", {31'd0, timeout_o}, 32'd0);
        rst = 0;
        remote_en = 1;
        @(negedge clk);
`endif

        chk_en = 0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
